// File: rtl/tdm_demux4.sv
// Receive-side 4-channel TDM deserializer: bit-interleaved slots 0..3, words sent MSB first,
// frame-locked on sync, four parallel words presented with a one-cycle valid pulse.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             sync,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic             word_valid,
    output logic             locked,
    output logic             sync_err
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]                r_state;
    logic [1:0]                r_slot;
    logic [BW-1:0]             r_bit;
    logic [3:0][WIDTH-1:0]     r_sh;
    logic [3:0][WIDTH-1:0]     r_q;
    logic                      r_wv;
    logic                      r_err;

    logic                      w_first;
    logic                      w_last;
    logic [WIDTH-1:0]          w_sh_next;
    logic [4*WIDTH-1:0]        w_fresh;

    assign w_first   = (r_slot == 2'd0) && (r_bit == '0);
    assign w_last    = (r_slot == 2'd3) && (r_bit == BIT_LAST);
    assign w_sh_next = {r_sh[r_slot][WIDTH-2:0], din};
    // A re-framed group starts with only the incoming bit in channel 0.
    assign w_fresh   = {{(4*WIDTH-1){1'b0}}, din};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
            r_slot  <= 2'd0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_q     <= '0;
            r_wv    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_wv <= 1'b0;
            if (en) begin
                case (r_state)
                    HUNT: begin
                        if (sync) begin
                            r_sh    <= w_fresh;
                            r_slot  <= 2'd1;
                            r_bit   <= '0;
                            r_state <= LOCKED;
                        end
                    end
                    default: begin
                        if (sync && !w_first) begin
                            r_err  <= 1'b1;
                            r_sh   <= w_fresh;
                            r_slot <= 2'd1;
                            r_bit  <= '0;
                        end else if (!sync && w_first) begin
                            r_err   <= 1'b1;
                            r_state <= HUNT;
                            r_slot  <= 2'd0;
                            r_bit   <= '0;
                        end else begin
                            r_sh[r_slot] <= w_sh_next;
                            r_slot       <= r_slot + 2'd1;
                            if (r_slot == 2'd3) begin
                                if (w_last) begin
                                    r_bit <= '0;
                                    // Channel 3 completes with the bit arriving on this edge.
                                    r_q   <= {w_sh_next, r_sh[2], r_sh[1], r_sh[0]};
                                    r_wv  <= 1'b1;
                                end else begin
                                    r_bit <= r_bit + 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign {s1, s0}   = r_slot;
    assign q0         = r_q[0];
    assign q1         = r_q[1];
    assign q2         = r_q[2];
    assign q3         = r_q[3];
    assign word_valid = r_wv;
    assign locked     = (r_state == LOCKED);
    assign sync_err   = r_err;
endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: table of word groups serialized bit-interleaved, a scoreboard of
// expected groups popped on each word_valid, plus hand sequences for framing errors and reset.
module tb_tdm_demux4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         din = 1'b0;
    logic         en = 1'b0;
    logic         sync = 1'b0;
    logic         s1, s0, word_valid, locked, sync_err;
    logic [W-1:0] q0, q1, q2, q3;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .din(din), .en(en), .sync(sync),
        .s1(s1), .s0(s0), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .word_valid(word_valid), .locked(locked), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pulse = 0;
    logic [31:0] sb[$];
    logic [31:0] m_exp;

    typedef struct {
        logic [31:0] grp;
        logic [7:0]  e0, e1, e2, e3;
        bit          gaps;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every word_valid cycle must match the oldest expected group.
    always @(negedge clk) begin
        if (word_valid) begin
            n_pulse++;
            if (sb.size() == 0) chk("unexpected_word_valid", 32'd1, 32'd0);
            else begin
                m_exp = sb.pop_front();
                chk("q0", q0, m_exp[31:24]);
                chk("q1", q1, m_exp[23:16]);
                chk("q2", q2, m_exp[15:8]);
                chk("q3", q3, m_exp[7:0]);
            end
        end
    end

    task automatic bit_in(input logic d, input logic s);
        @(negedge clk);
        din = d; sync = s; en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input bit check_frozen);
        logic [1:0] sl;
        sl = {s1, s0};
        repeat (n) begin
            @(negedge clk);
            en = 1'b0; din = 1'($urandom); sync = 1'($urandom);
            @(posedge clk); #1;
            if (check_frozen) begin
                chk("gap_slot", {30'd0, s1, s0}, {30'd0, sl});
                chk("gap_wv", word_valid, 0);
            end
        end
    endtask

    // Accepted bit k carries slot k%4, bit position k/4 of that channel's word.
    task automatic send(input logic [31:0] g, input int from, input int to,
                        input bit nosync, input bit gaps);
        for (int k = from; k <= to; k++) begin
            bit_in(g[31 - 8*(k%4) - k/4], (k == 0) && !nosync);
            if (gaps && (k == 4 || k == 16 || k == 30)) idle(3, 1);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk); rst = 1'b1;
        #3 rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'hA53CFF01, 8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0};
        tbl[1] = '{32'hA53CFF01, 8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1};
        tbl[2] = '{32'h12345678, 8'h12, 8'h34, 8'h56, 8'h78, 1'b0};
        tbl[3] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4] = '{32'h80FF7E01, 8'h80, 8'hFF, 8'h7E, 8'h01, 1'b0};

        rst = 1'b1;
        #12;
        chk("rst_q", {q0, q1, q2, q3}, 32'd0);
        chk("rst_wv", word_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", sync_err, 0);
        chk("rst_slot", {30'd0, s1, s0}, 0);
        @(negedge clk); rst = 1'b0;

        // Nominal, gapped and back-to-back groups.
        for (int i = 0; i < 5; i++) begin
            sb.push_back({tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3});
            send(tbl[i].grp, 0, 31, 1'b0, tbl[i].gaps);
            chk("wv_after_last", word_valid, 1);
            chk("locked", locked, 1);
            chk("err_clean", sync_err, 0);
            chk("slot_wrap", {30'd0, s1, s0}, 0);
        end
        idle(1, 0);
        chk("pulses_table", n_pulse, 5);

        // Misplaced sync on the 10th accepted bit re-frames from that bit.
        pulse_rst();
        send(32'hDEADBEEF, 0, 8, 1'b0, 1'b0);
        sb.push_back(32'h5AC3_0F96);
        send(32'h5AC3_0F96, 0, 0, 1'b0, 1'b0);
        chk("mis_err", sync_err, 1);
        chk("mis_slot", {30'd0, s1, s0}, 1);
        chk("mis_locked", locked, 1);
        send(32'h5AC3_0F96, 1, 31, 1'b0, 1'b0);
        chk("mis_wv", word_valid, 1);
        idle(2, 0);
        chk("pulses_mis", n_pulse, 6);

        // Missing sync on the next group's first bit drops to HUNT.
        pulse_rst();
        sb.push_back(32'h1122_3344);
        send(32'h1122_3344, 0, 31, 1'b0, 1'b0);
        chk("ms_wv1", word_valid, 1);
        send(32'hCAFE_F00D, 0, 0, 1'b1, 1'b0);
        chk("ms_err", sync_err, 1);
        chk("ms_locked", locked, 0);
        chk("ms_slot", {30'd0, s1, s0}, 0);
        send(32'hCAFE_F00D, 1, 31, 1'b1, 1'b0);
        chk("ms_hunt_locked", locked, 0);
        chk("ms_hunt_wv", word_valid, 0);
        sb.push_back(32'hE7_18_C3_3C);
        send(32'hE718C33C, 0, 31, 1'b0, 1'b0);
        chk("ms_wv2", word_valid, 1);
        chk("ms_relock", locked, 1);
        idle(2, 0);
        chk("pulses_ms", n_pulse, 8);

        // Asynchronous reset between edges after 20 bits.
        send(32'h0BAD_CAFE, 0, 19, 1'b0, 1'b0);
        @(negedge clk); en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("amr_q", {q0, q1, q2, q3}, 32'd0);
        chk("amr_locked", locked, 0);
        chk("amr_err", sync_err, 0);
        chk("amr_slot", {30'd0, s1, s0}, 0);
        #1 rst = 1'b0;
        sb.push_back(32'h6996_A55A);
        send(32'h6996A55A, 0, 31, 1'b0, 1'b0);
        chk("amr_wv", word_valid, 1);

        idle(3, 0);
        chk("sb_empty", sb.size(), 0);
        chk("pulses_total", n_pulse, 9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the team's 4-to-1 channel multiplexer.
- Takes a 1-bit time-division stream in which four channels are interleaved bit-by-bit in slot order 0,1,2,3, sending each channel word MSB first.
- Tracks the slot and bit position, deserializes each channel, and presents four parallel words with a one-cycle valid strobe.
- Sits between the serial link input and the per-channel consumers.

Parameters:
WIDTH, 8, bits per channel word (legal range 2..16)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
din  input  1  serial data bit, sampled when en=1
en  input  1  bit-valid qualifier; en=0 cycles are ignored entirely
sync  input  1  frame marker, asserted with the slot-0 bit of bit position 0 (MSB) of each word group
s1  output  1  MSB of slot index expected for the next accepted bit
s0  output  1  LSB of slot index expected for the next accepted bit
q0  output  WIDTH  last completed word, channel 0
q1  output  WIDTH  last completed word, channel 1
q2  output  WIDTH  last completed word, channel 2
q3  output  WIDTH  last completed word, channel 3
word_valid  output  1  one-cycle pulse when q0..q3 update
locked  output  1  1 while in LOCKED state
sync_err  output  1  sticky framing-error flag, cleared only by rst

Behaviour:
Reset:
- Asynchronous, active-high.
- Outputs on reset: q0..q3=0, word_valid=0, sync_err=0, locked=0, {s1,s0}=0.
- Internal state on reset: state=HUNT, bit counter=0, shift registers=0.
- Reset asserted mid-word discards all partial data; q0..q3 return to 0.

Accepted bit:
- A cycle with en=1. All rules below apply only to accepted bits.
- en=0: every register holds, word_valid=0.

State HUNT:
- Bits without sync are discarded.
- Accepted bit with sync=1: shifted into channel 0 as bit WIDTH-1; slot becomes 1; bit counter=0; go to LOCKED.

State LOCKED:
- Each accepted bit is shifted into the shift register of the current slot (shift left, din enters LSB).
- Slot increments mod 4. {s1,s0} always shows the current slot.
- The slot-3 bit increments the bit counter (0..WIDTH-1, wraps to 0).
- Completion: at the slot-3 bit with bit counter=WIDTH-1, on that same edge the four completed words (channel 3 including the incoming bit) load into q0..q3, and word_valid=1 for exactly the following cycle.
- Latency: q and word_valid are visible one edge after the final bit is sampled.
- Back-to-back words need no idle cycle. The next word's slot-0 bit must carry sync=1.

Framing errors (in LOCKED):
- sync=1 on any bit other than slot 0 / bit 0: sync_err set. The bit is treated as a fresh slot-0 MSB; partial shift data is discarded (other channels cleared), bit counter=0; stays LOCKED. q0..q3 are not updated.
- sync=0 on slot 0 / bit 0: sync_err set, the bit is discarded, go to HUNT, locked=0, {s1,s0}=0.
- sync on slots 1..3 or on bit positions >0 is an error as described above.

Output hold:
- word_valid never pulses on a partial word.
- q0..q3 hold their values until the next completion or rst.

Test Plan:
- Nominal word: WIDTH=8, rst pulse, then 32 accepted bits interleaving q0=0xA5, q1=0x3C, q2=0xFF, q3=0x01 MSB first, sync on the first bit -> after the 32nd bit, q0..q3 = A5/3C/FF/01, word_valid high exactly 1 cycle, locked=1, sync_err=0, {s1,s0}=0.
- Idle gaps: same stream with en=0 inserted for 3 cycles after bits 5, 17 and 31 -> identical q values; word_valid delayed by exactly the gap cycles; {s1,s0} frozen during gaps.
- Back-to-back: second group 0x12/0x34/0x56/0x78 directly after the first, sync on bit 33 -> two word_valid pulses 32 accepted bits apart; q shows the second group after the second pulse; sync_err=0.
- Misplaced sync: sync=1 on the 10th accepted bit (slot 1) -> sync_err=1, {s1,s0}=1 next cycle; a clean 32-bit group starting from that bit produces the correct q and a word_valid pulse.
- Missing sync: after one good group, the next slot-0 MSB arrives with sync=0 -> sync_err=1, locked=0, no word_valid; bits are ignored until sync=1, then a good group decodes correctly.
- Reset mid-word: rst asserted asynchronously (between edges) after 20 bits -> q0..q3=0, locked=0, sync_err=0 immediately; a subsequent full group decodes normally.
